// File: rtl/dram_pkg.sv
// Shared constants and helpers for the DRAM address mapper.
package dram_pkg;

  // Row-buffer classification codes carried on out_hit
  localparam logic [1:0] HIT      = 2'b00;
  localparam logic [1:0] MISS     = 2'b01;
  localparam logic [1:0] CONFLICT = 2'b10;

  // Address layouts
  localparam int MAP_INTERLEAVED = 0;  // {row,bank,col,offset}
  localparam int MAP_LINEAR      = 1;  // {bank,row,col,offset}

  // Width of a field indexing n entries (at least one bit)
  function automatic int fld_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // Total address width implied by the field layout
  function automatic int addr_w(input int ow, input int nb, input int nr, input int nc);
    return ow + fld_w(nb) + fld_w(nr) + fld_w(nc);
  endfunction

  // Classify a request against the open-row state of its bank
  function automatic logic [1:0] classify(input logic vld, input logic row_eq);
    if (!vld) begin
      return MISS;
    end else if (row_eq) begin
      return HIT;
    end else begin
      return CONFLICT;
    end
  endfunction

endpackage

// File: rtl/dram_open_row_table.sv
// Per-bank open-row tracker: precharge closes, open write sets {vld,row}.
// The open write wins over a precharge of the same bank in the same cycle.
module dram_open_row_table
  import dram_pkg::*;
#(
  parameter  int NUM_OF_BANKS = 8,
  parameter  int ROW_W        = 7,
  localparam int BANK_W       = fld_w(NUM_OF_BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pre_valid,
  input  logic [BANK_W-1:0] pre_bank,
  input  logic              pre_all,
  input  logic              open_en,
  input  logic [BANK_W-1:0] open_bank,
  input  logic [ROW_W-1:0]  open_row,
  input  logic [BANK_W-1:0] lookup_bank,
  output logic              lookup_vld,
  output logic [ROW_W-1:0]  lookup_row
);

  logic [NUM_OF_BANKS-1:0] r_vld;
  logic [ROW_W-1:0]        r_row [NUM_OF_BANKS];

  // Table update: precharge first, then the activation of the handed-off request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        r_row[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        if (open_en && (open_bank == BANK_W'(b))) begin
          r_vld[b] <= 1'b1;
          r_row[b] <= open_row;
        end else if (pre_all || (pre_valid && (pre_bank == BANK_W'(b)))) begin
          r_vld[b] <= 1'b0;
        end
      end
    end
  end

  assign lookup_vld = r_vld[lookup_bank];
  assign lookup_row = r_row[lookup_bank];

endmodule

// File: rtl/dram_addr_mapper.sv
// Registered address mapper: slices the request address into bank/row/col/offset
// and tags it HIT/MISS/CONFLICT against the open-row state after this cycle's updates.
module dram_addr_mapper
  import dram_pkg::*;
#(
  parameter  int ADDR_WIDTH   = 20,
  parameter  int NUM_OF_BANKS = 8,
  parameter  int NUM_OF_ROWS  = 128,
  parameter  int NUM_OF_COLS  = 8,
  parameter  int OFFSET_WIDTH = 7,
  parameter  int MAP_MODE     = 0,
  localparam int BANK_W       = fld_w(NUM_OF_BANKS),
  localparam int ROW_W        = fld_w(NUM_OF_ROWS),
  localparam int COL_W        = fld_w(NUM_OF_COLS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic                    in_we,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BANK_W-1:0]       out_bank,
  output logic [ROW_W-1:0]        out_row,
  output logic [COL_W-1:0]        out_col,
  output logic [OFFSET_WIDTH-1:0] out_offset,
  output logic                    out_we,
  output logic [1:0]              out_hit,
  input  logic                    pre_valid,
  input  logic [BANK_W-1:0]       pre_bank,
  input  logic                    pre_all
);

  localparam int COL_LSB = OFFSET_WIDTH;
  localparam int MID_LSB = OFFSET_WIDTH + COL_W;

  if (ADDR_WIDTH != addr_w(OFFSET_WIDTH, NUM_OF_BANKS, NUM_OF_ROWS, NUM_OF_COLS)) begin : g_width_err
    $error("dram_addr_mapper: ADDR_WIDTH does not match the field layout");
  end

  logic                    r_out_valid;
  logic [BANK_W-1:0]       r_bank;
  logic [ROW_W-1:0]        r_row;
  logic [COL_W-1:0]        r_col;
  logic [OFFSET_WIDTH-1:0] r_offset;
  logic                    r_we;
  logic [1:0]              r_hit;

  logic [BANK_W-1:0]       w_bank;
  logic [ROW_W-1:0]        w_row;
  logic [COL_W-1:0]        w_col;
  logic [OFFSET_WIDTH-1:0] w_offset;
  logic                    w_in_ready;
  logic                    w_load;
  logic                    w_out_hs;
  logic                    w_pre_in;
  logic                    w_open_in;
  logic                    w_pre_held;
  logic                    w_tbl_vld;
  logic [ROW_W-1:0]        w_tbl_row;
  logic                    w_nxt_vld;
  logic [ROW_W-1:0]        w_nxt_row;
  logic [1:0]              w_hit;

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_load     = in_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && out_ready;
  assign w_pre_in   = pre_all || (pre_valid && (pre_bank == w_bank));
  assign w_open_in  = w_out_hs && (r_bank == w_bank);
  assign w_pre_held = pre_all || (pre_valid && (pre_bank == r_bank));

  // Address slicer for the selected layout
  always_comb begin
    w_offset = in_addr[OFFSET_WIDTH-1:0];
    w_col    = in_addr[MID_LSB-1:COL_LSB];
    if (MAP_MODE == MAP_LINEAR) begin
      w_row  = in_addr[MID_LSB+ROW_W-1:MID_LSB];
      w_bank = in_addr[MID_LSB+ROW_W+BANK_W-1:MID_LSB+ROW_W];
    end else begin
      w_bank = in_addr[MID_LSB+BANK_W-1:MID_LSB];
      w_row  = in_addr[MID_LSB+BANK_W+ROW_W-1:MID_LSB+BANK_W];
    end
  end

  dram_open_row_table #(
    .NUM_OF_BANKS (NUM_OF_BANKS),
    .ROW_W        (ROW_W)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .pre_valid   (pre_valid),
    .pre_bank    (pre_bank),
    .pre_all     (pre_all),
    .open_en     (w_out_hs),
    .open_bank   (r_bank),
    .open_row    (r_row),
    .lookup_bank (w_bank),
    .lookup_vld  (w_tbl_vld),
    .lookup_row  (w_tbl_row)
  );

  // Bypass: the incoming request sees the table as it will be after this cycle
  always_comb begin
    w_nxt_vld = w_tbl_vld;
    w_nxt_row = w_tbl_row;
    if (w_open_in) begin
      w_nxt_vld = 1'b1;
      w_nxt_row = r_row;
    end else if (w_pre_in) begin
      w_nxt_vld = 1'b0;
    end else begin
      w_nxt_vld = w_tbl_vld;
    end
    w_hit = classify(w_nxt_vld, w_nxt_row == w_row);
  end

  // Output register: load, drain, or demote a stalled entry to MISS on precharge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_bank      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_offset    <= '0;
      r_we        <= 1'b0;
      r_hit       <= 2'b00;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_bank      <= w_bank;
      r_row       <= w_row;
      r_col       <= w_col;
      r_offset    <= w_offset;
      r_we        <= in_we;
      r_hit       <= w_hit;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end else if (r_out_valid && w_pre_held) begin
      r_hit       <= MISS;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_bank   = r_bank;
  assign out_row    = r_row;
  assign out_col    = r_col;
  assign out_offset = r_offset;
  assign out_we     = r_we;
  assign out_hit    = r_hit;

endmodule

// File: tb/tb_dram_addr_mapper.sv
// Self-checking bench for dram_addr_mapper: directed vectors plus a cycle model.
module tb_dram_addr_mapper;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_we, out_ready, pre_valid, pre_all;
  logic [19:0] in_addr;
  logic [2:0]  pre_bank;

  logic        in_ready, out_valid, out_we;
  logic [2:0]  out_bank, out_col;
  logic [6:0]  out_row, out_offset;
  logic [1:0]  out_hit;

  logic        in_ready1, out_valid1, out_we1;
  logic [2:0]  out_bank1, out_col1;
  logic [6:0]  out_row1, out_offset1;
  logic [1:0]  out_hit1;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  dram_addr_mapper #(.MAP_MODE(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_we(in_we), .out_valid(out_valid), .out_ready(out_ready), .out_bank(out_bank),
    .out_row(out_row), .out_col(out_col), .out_offset(out_offset), .out_we(out_we),
    .out_hit(out_hit), .pre_valid(pre_valid), .pre_bank(pre_bank), .pre_all(pre_all)
  );

  dram_addr_mapper #(.MAP_MODE(1)) u_dut_lin (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_addr(in_addr),
    .in_we(in_we), .out_valid(out_valid1), .out_ready(out_ready), .out_bank(out_bank1),
    .out_row(out_row1), .out_col(out_col1), .out_offset(out_offset1), .out_we(out_we1),
    .out_hit(out_hit1), .pre_valid(pre_valid), .pre_bank(pre_bank), .pre_all(pre_all)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  bit m_vld [8];
  int m_row [8];
  bit e_valid, e_we;
  int e_bank, e_row, e_col, e_off, e_hit, e1_bank, e1_row;
  bit acc, hs, pre_held;
  int a, mb, mr;

  // Model of one clock: precharges, then the handed-off activation, then the new request
  always @(posedge clk) begin
    if (rst) begin
      e_valid = 1'b0; e_we = 1'b0;
      e_bank = 0; e_row = 0; e_col = 0; e_off = 0; e_hit = 0; e1_bank = 0; e1_row = 0;
      for (int b = 0; b < 8; b++) m_vld[b] = 1'b0;
    end else begin
      acc      = in_valid && (!e_valid || out_ready);
      hs       = e_valid && out_ready;
      pre_held = pre_all || (pre_valid && (int'(pre_bank) == e_bank));
      for (int b = 0; b < 8; b++)
        if (pre_all || (pre_valid && int'(pre_bank) == b)) m_vld[b] = 1'b0;
      if (hs) begin
        m_vld[e_bank] = 1'b1;
        m_row[e_bank] = e_row;
      end
      if (acc) begin
        a       = int'(in_addr);
        e_off   = a % 128;
        e_col   = (a / 128) % 8;
        mb      = (a / 1024) % 8;
        mr      = a / 8192;
        e_bank  = mb;
        e_row   = mr;
        e1_row  = (a / 1024) % 128;
        e1_bank = a / 131072;
        e_we    = in_we;
        e_hit   = !m_vld[mb] ? 1 : ((m_row[mb] == mr) ? 0 : 2);
        e_valid = 1'b1;
      end else if (hs) begin
        e_valid = 1'b0;
      end else if (e_valid && pre_held) begin
        e_hit = 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_out_valid", {31'd0, out_valid}, {31'd0, e_valid});
      check("m_in_ready", {31'd0, in_ready}, {31'd0, (!e_valid || out_ready)});
      if (e_valid) begin
        check("m_bank", 32'(out_bank), e_bank);
        check("m_row", 32'(out_row), e_row);
        check("m_col", 32'(out_col), e_col);
        check("m_offset", 32'(out_offset), e_off);
        check("m_we", {31'd0, out_we}, {31'd0, e_we});
        check("m_hit", 32'(out_hit), e_hit);
        check("m_lin_bank", 32'(out_bank1), e1_bank);
        check("m_lin_row", 32'(out_row1), e1_row);
        check("m_lin_col", 32'(out_col1), e_col);
      end
    end
  end

  logic [19:0] vec_addr [12];

  initial begin
    vec_addr[0]  = 20'h02C85; vec_addr[1]  = 20'h02C86; vec_addr[2]  = 20'h06C85;
    vec_addr[3]  = 20'h01400; vec_addr[4]  = 20'h01455; vec_addr[5]  = 20'hFFFFF;
    vec_addr[6]  = 20'hFE3FF; vec_addr[7]  = 20'h00000; vec_addr[8]  = 20'h02C85;
    vec_addr[9]  = 20'h41401; vec_addr[10] = 20'h41402; vec_addr[11] = 20'h81C00;

    rst = 1'b1; in_valid = 1'b0; in_we = 1'b0; in_addr = 20'h0;
    out_ready = 1'b1; pre_valid = 1'b0; pre_bank = 3'd0; pre_all = 1'b0;
    tick(); tick();
    cmp_en = 1'b1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_hit", 32'(out_hit), 32'd0);
    check("rst_bank", 32'(out_bank), 32'd0);
    rst = 1'b0;

    // Basic slice and MISS after reset, both layouts
    in_valid = 1'b1; in_addr = 20'h02C85; tick(); in_valid = 1'b0;
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_bank", 32'(out_bank), 32'd3);
    check("t1_row", 32'(out_row), 32'd1);
    check("t1_col", 32'(out_col), 32'd1);
    check("t1_off", 32'(out_offset), 32'd5);
    check("t1_hit", 32'(out_hit), 32'd1);
    check("t1_lin_bank", 32'(out_bank1), 32'd0);
    check("t1_lin_row", 32'(out_row1), 32'd11);
    check("t1_lin_col", 32'(out_col1), 32'd1);
    check("t1_lin_off", 32'(out_offset1), 32'd5);
    tick();

    // Back-to-back MISS, HIT, CONFLICT through the bypass
    pre_all = 1'b1; tick(); pre_all = 1'b0;
    in_valid = 1'b1; in_addr = 20'h02C85; tick();
    check("t2_miss", 32'(out_hit), 32'd1);
    in_addr = 20'h02C80; in_we = 1'b1; tick();
    check("t2_hit", 32'(out_hit), 32'd0);
    check("t2_we", {31'd0, out_we}, 32'd1);
    in_addr = 20'h06C85; in_we = 1'b0; tick();
    check("t2_conflict", 32'(out_hit), 32'd2);
    check("t2_row", 32'(out_row), 32'd3);
    in_valid = 1'b0; tick();

    // Stalled HIT demoted to MISS by a precharge of its bank
    out_ready = 1'b0; in_valid = 1'b1; in_addr = 20'h06C85; tick();
    check("t3_hit", 32'(out_hit), 32'd0);
    in_addr = 20'h00000; pre_valid = 1'b1; pre_bank = 3'd3; #1;
    check("t3_in_ready", {31'd0, in_ready}, 32'd0);
    tick(); pre_valid = 1'b0;
    check("t3_demote", 32'(out_hit), 32'd1);
    check("t3_bank", 32'(out_bank), 32'd3);
    check("t3_row", 32'(out_row), 32'd3);
    check("t3_off", 32'(out_offset), 32'd5);
    in_valid = 1'b0; out_ready = 1'b1; tick();

    // pre_all coinciding with the handoff of bank 3 row 1
    out_ready = 1'b0; in_valid = 1'b1; in_addr = 20'h02C85; tick();
    check("t4_conflict", 32'(out_hit), 32'd2);
    in_valid = 1'b0; out_ready = 1'b1; pre_all = 1'b1; tick(); pre_all = 1'b0;
    in_valid = 1'b1; in_addr = 20'h02C85; tick();
    check("t4_hit_after_preall", 32'(out_hit), 32'd0);
    in_addr = 20'h01400; tick();
    check("t4_bank5", 32'(out_bank), 32'd5);
    check("t4_bank5_miss", 32'(out_hit), 32'd1);
    in_valid = 1'b0; tick();

    // Reset while a request is stalled
    out_ready = 1'b0; in_valid = 1'b1; in_addr = 20'h02C85; tick();
    check("t5_held", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; in_addr = 20'h01400; tick();
    check("t5_dropped", {31'd0, out_valid}, 32'd0);
    rst = 1'b0; out_ready = 1'b1; in_addr = 20'h02C85; tick();
    check("t5_post_rst_miss", 32'(out_hit), 32'd1);
    in_valid = 1'b0; tick();

    // Mixed stream with backpressure and precharges, checked by the model
    for (int i = 0; i < 36; i++) begin
      in_valid  = (i % 5) != 4;
      in_addr   = vec_addr[i % 12];
      in_we     = (i % 3) == 1;
      out_ready = (i % 4) != 2;
      pre_valid = (i % 7) == 3;
      pre_bank  = 3'(i % 8);
      pre_all   = (i % 11) == 6;
      tick();
    end
    in_valid = 1'b0; pre_valid = 1'b0; pre_all = 1'b0; out_ready = 1'b1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
